// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcodes, field slices, immediate widths
// and control-bundle bit offsets for the ID stage.
package decode_stage_pkg;

  localparam int INST_ID_LEN = 6;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int IMM_I_W = 12;
  localparam int IMM_S_W = 12;
  localparam int IMM_B_W = 13;
  localparam int IMM_U_W = 32;
  localparam int IMM_J_W = 21;

  // Bundle layout {rs1_re, rs2_re, rd_we, mem_re, mem_we, instr_id}
  localparam int CTRL_MEM_WE = INST_ID_LEN;
  localparam int CTRL_MEM_RE = INST_ID_LEN + 1;
  localparam int CTRL_RD_WE  = INST_ID_LEN + 2;
  localparam int CTRL_RS2_RE = INST_ID_LEN + 3;
  localparam int CTRL_RS1_RE = INST_ID_LEN + 4;

  function automatic logic [6:0] f_opcode(logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [4:0] f_rd(logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic logic [2:0] f_funct3(logic [31:0] i);
    return i[14:12];
  endfunction

  function automatic logic [4:0] f_rs1(logic [31:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(logic [31:0] i);
    return i[24:20];
  endfunction

  function automatic logic [6:0] f_funct7(logic [31:0] i);
    return i[31:25];
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B/U/J format from the opcode
// and sign-extends from instr_i[31] to XLEN.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [IMM_I_W-1:0] imm_i;
  logic [IMM_S_W-1:0] imm_s;
  logic [IMM_B_W-1:0] imm_b;
  logic [IMM_U_W-1:0] imm_u;
  logic [IMM_J_W-1:0] imm_j;
  logic [31:0]        imm32;

  assign imm_i = instr_i[31:20];
  assign imm_s = {instr_i[31:25], instr_i[11:7]};
  assign imm_b = {instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Format select on opcode; unknown opcodes give zero
  always_comb begin
    imm32 = '0;
    unique case (f_opcode(instr_i))
      OPC_OP_IMM,
      OPC_LOAD,
      OPC_JALR:   imm32 = 32'($signed(imm_i));
      OPC_LUI,
      OPC_AUIPC:  imm32 = imm_u;
      OPC_STORE:  imm32 = 32'($signed(imm_s));
      OPC_BRANCH: imm32 = 32'($signed(imm_b));
      OPC_JAL:    imm32 = 32'($signed(imm_j));
      default:    imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// ID stage: field decode, load-use stall, ID/EXE pipeline register.
// DECODE_WB_FWD_EN enables writeback-to-decode operand bypass.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5 + INST_ID_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   rs1_val_i,
  input  logic [XLEN-1:0]   rs2_val_i,
  input  logic              exe_mem_re_i,
  input  logic [4:0]        exe_rd_addr_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [XLEN-1:0]   out_imm_o,
  output logic [XLEN-1:0]   out_rs1_val_o,
  output logic [XLEN-1:0]   out_rs2_val_o,
  output logic [4:0]        out_rs1_addr_o,
  output logic [4:0]        out_rs2_addr_o,
  output logic [4:0]        out_rd_addr_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  logic              valid_q, valid_d, load;
  logic [XLEN-1:0]   pc_q, imm_q, rs1v_q, rs2v_q;
  logic [4:0]        rs1a_q, rs2a_q, rd_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic            advance, hazard, accept;
  logic            rs1_re, rs2_re, rd_we;
  logic [4:0]      rd_dec;
  logic [XLEN-1:0] imm, rs1_fwd, rs2_fwd;

  assign rs1_addr_o = f_rs1(instr_i);
  assign rs2_addr_o = f_rs2(instr_i);
  assign opcode_o   = f_opcode(instr_i);
  assign funct3_o   = f_funct3(instr_i);
  assign funct7_o   = f_funct7(instr_i);

  assign rs1_re = ctrl_i[CTRL_RS1_RE];
  assign rs2_re = ctrl_i[CTRL_RS2_RE];
  assign rd_we  = ctrl_i[CTRL_RD_WE];
  assign rd_dec = rd_we ? f_rd(instr_i) : 5'd0;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr_i),
    .imm_o   (imm)
  );

`ifdef DECODE_WB_FWD_EN
  logic wb_hit1, wb_hit2;
  assign wb_hit1 = wb_we_i && (wb_rd_addr_i != 5'd0)
                && (wb_rd_addr_i == rs1_addr_o);
  assign wb_hit2 = wb_we_i && (wb_rd_addr_i != 5'd0)
                && (wb_rd_addr_i == rs2_addr_o);
  assign rs1_fwd = wb_hit1 ? wb_data_i : rs1_val_i;
  assign rs2_fwd = wb_hit2 ? wb_data_i : rs2_val_i;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_rd_addr_i, wb_data_i};
  assign rs1_fwd   = rs1_val_i;
  assign rs2_fwd   = rs2_val_i;
`endif

  assign advance = !valid_q || out_ready_i;
  assign hazard  = in_valid_i && exe_mem_re_i
                && (exe_rd_addr_i != 5'd0)
                && ((rs1_re && rs1_addr_o == exe_rd_addr_i)
                 || (rs2_re && rs2_addr_o == exe_rd_addr_i));
  assign in_ready_o = advance && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  // Next valid: flush kills, advancing without accept leaves a bubble
  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = accept;
      load    = accept;
    end
  end

  // ID/EXE register; payload only changes on an accepted instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1v_q  <= '0;
      rs2v_q  <= '0;
      rs1a_q  <= '0;
      rs2a_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        pc_q   <= pc_i;
        imm_q  <= imm;
        rs1v_q <= rs1_fwd;
        rs2v_q <= rs2_fwd;
        rs1a_q <= rs1_addr_o;
        rs2a_q <= rs2_addr_o;
        rd_q   <= rd_dec;
        ctrl_q <= ctrl_i;
      end
    end
  end

  assign out_valid_o    = valid_q;
  assign out_pc_o       = pc_q;
  assign out_imm_o      = imm_q;
  assign out_rs1_val_o  = rs1v_q;
  assign out_rs2_val_o  = rs2v_q;
  assign out_rs1_addr_o = rs1a_q;
  assign out_rs2_addr_o = rs2a_q;
  assign out_rd_addr_o  = rd_q;
  assign out_ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage at XLEN=64.
// Covers decode, immediates, load-use bubble, stall, flush, reset.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 5 + INST_ID_LEN;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       instr;
  logic [XLEN-1:0]   pc;
  logic [4:0]        rs1_addr, rs2_addr;
  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [CTRL_W-1:0] ctrl;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              exe_mem_re;
  logic [4:0]        exe_rd;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_imm, out_rs1v, out_rs2v;
  logic [4:0]        out_rs1a, out_rs2a, out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .instr_i        (instr),
    .pc_i           (pc),
    .rs1_addr_o     (rs1_addr),
    .rs2_addr_o     (rs2_addr),
    .opcode_o       (opcode),
    .funct3_o       (funct3),
    .funct7_o       (funct7),
    .ctrl_i         (ctrl),
    .rs1_val_i      (rs1_val),
    .rs2_val_i      (rs2_val),
    .exe_mem_re_i   (exe_mem_re),
    .exe_rd_addr_i  (exe_rd),
    .wb_we_i        (wb_we),
    .wb_rd_addr_i   (wb_rd),
    .wb_data_i      (wb_data),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_imm_o      (out_imm),
    .out_rs1_val_o  (out_rs1v),
    .out_rs2_val_o  (out_rs2v),
    .out_rs1_addr_o (out_rs1a),
    .out_rs2_addr_o (out_rs2a),
    .out_rd_addr_o  (out_rd),
    .out_ctrl_o     (out_ctrl)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] mk_ctrl(
    input logic r1, input logic r2, input logic we,
    input logic mr, input logic mw,
    input logic [INST_ID_LEN-1:0] id);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_RS1_RE] = r1;
    c[CTRL_RS2_RE] = r2;
    c[CTRL_RD_WE]  = we;
    c[CTRL_MEM_RE] = mr;
    c[CTRL_MEM_WE] = mw;
    c[INST_ID_LEN-1:0] = id;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic [XLEN-1:0] p,
                       input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    ctrl     = c;
  endtask

  logic [CTRL_W-1:0] c_addi;
  logic [63:0]       fwd_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0;
    ctrl = '0; rs1_val = '0; rs2_val = '0;
    exe_mem_re = 1'b0; exe_rd = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 64'(in_ready), 64'd1);

    c_addi = mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    drive(32'hFFF00093, 64'h100, c_addi);
    #1;
    check("addi_opc", 64'(opcode), 64'h13);
    check("addi_rs1a", 64'(rs1_addr), 64'd0);
    check("addi_f3", 64'(funct3), 64'd0);
    tick();
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_pc", out_pc, 64'h100);
    check("addi_ctrl", 64'(out_ctrl), 64'(c_addi));

    drive(32'h800000B7, 64'h104,
          mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2));
    tick();
    check("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui_rd", 64'(out_rd), 64'd1);

    drive(32'hFE20AE23, 64'h108,
          mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3));
    tick();
    check("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("sw_rd_zero", 64'(out_rd), 64'd0);
    check("sw_rs2a", 64'(out_rs2a), 64'd2);

    drive(32'h00208863, 64'h10C,
          mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4));
    tick();
    check("beq_imm", out_imm, 64'h10);

    drive(32'hFFDFF06F, 64'h110,
          mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5));
    tick();
    check("jal_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    exe_mem_re = 1'b1;
    exe_rd     = 5'd5;
    drive(32'h00728333, 64'h200,
          mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd6));
    #1;
    check("hz_ready", 64'(in_ready), 64'd0);
    check("add_f7", 64'(funct7), 64'd0);
    check("add_rs2a_comb", 64'(rs2_addr), 64'd7);
    tick();
    check("hz_bubble", 64'(out_valid), 64'd0);
    check("hz_pc_hold", out_pc, 64'h110);
    exe_mem_re = 1'b0;
    #1;
    check("hz_ready_rel", 64'(in_ready), 64'd1);
    tick();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_rd", 64'(out_rd), 64'd6);
    check("add_rs1a", 64'(out_rs1a), 64'd5);
    check("add_rs2a", 64'(out_rs2a), 64'd7);
    check("add_imm", out_imm, 64'd0);
    check("add_pc", out_pc, 64'h200);

    out_ready = 1'b0;
    drive(32'h00100113, 64'h204, c_addi);
    #1;
    check("st_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_pc", out_pc, 64'h200);
      check("st_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("st_ready_rel", 64'(in_ready), 64'd1);
    tick();
    check("st_next_pc", out_pc, 64'h204);
    check("st_next_rd", 64'(out_rd), 64'd2);
    check("st_next_imm", out_imm, 64'd1);
    in_valid = 1'b0;
    tick();
    check("st_once", 64'(out_valid), 64'd0);

    drive(32'h00100113, 64'h300, c_addi);
    tick();
    check("fl_pre_valid", 64'(out_valid), 64'd1);
    exe_mem_re = 1'b1;
    exe_rd     = 5'd5;
    flush      = 1'b1;
    drive(32'h00728333, 64'h304,
          mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd6));
    #1;
    check("fl_ready", 64'(in_ready), 64'd0);
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_pc", out_pc, 64'h300);
    flush      = 1'b0;
    exe_mem_re = 1'b0;

    rs1_val = '0;
    rs2_val = 64'h55;
    wb_we   = 1'b1;
    wb_rd   = 5'd3;
    wb_data = 64'hDEAD;
    drive(32'h00018213, 64'h400,
          mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8));
`ifdef DECODE_WB_FWD_EN
    fwd_exp = 64'hDEAD;
`else
    fwd_exp = 64'd0;
`endif
    tick();
    check("fwd_rs1", out_rs1v, fwd_exp);
    check("fwd_rs2", out_rs2v, 64'h55);
    wb_we = 1'b0;

    drive(32'h00100113, 64'h500, c_addi);
    tick();
    out_ready = 1'b0;
    drive(32'h00100113, 64'h504, c_addi);
    tick();
    check("rs_stall_pc", out_pc, 64'h500);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_pc", out_pc, 64'd0);
    check("rs_imm", out_imm, 64'd0);
    check("rs_ctrl", 64'(out_ctrl), 64'd0);
    check("rs_rd", 64'(out_rd), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rs_no_out", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
